// File: rtl/axil_reg_slave.sv
// AXI-Lite register slave: three R/W control words plus a read-only status word.
// Write channel is a small AW/W join FSM; the read channel runs independently.
module axil_reg_slave #(
  parameter logic [31:0] RST_VAL0 = 32'h0,
  parameter logic [31:0] RST_VAL1 = 32'h0,
  parameter logic [31:0] RST_VAL2 = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic        s_bvalid,
  output logic [1:0]  s_bresp,
  input  logic        s_bready,
  input  logic [3:0]  s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  input  logic        s_rready,
  output logic [31:0] ctrl0,
  output logic [31:0] ctrl1,
  output logic [31:0] ctrl2,
  input  logic [31:0] status_in,
  output logic [2:0]  wr_pulse
);

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_COMMIT,
    W_RESP
  } wstate_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  wstate_e     state_q, state_d;
  logic [3:0]  awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [2:0]  pulse_q, pulse_d;
  logic [31:0] ctrl_q [3];
  logic [31:0] ctrl_d [3];
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, wr_err;

  assign s_awready = ~rst & ((state_q == W_IDLE) | (state_q == W_DATA));
  assign s_wready  = ~rst & ((state_q == W_IDLE) | (state_q == W_ADDR));
  assign s_arready = ~rst & ~rvalid_q;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  assign wr_err = (awaddr_q[1:0] != 2'b00) | (awaddr_q[3:2] == 2'd3);

  always_comb begin
    state_d  = state_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    pulse_d  = 3'b000;
    ctrl_d   = ctrl_q;
    if (aw_hs) awaddr_d = s_awaddr;
    if (w_hs) begin
      wdata_d = s_wdata;
      wstrb_d = s_wstrb;
    end
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) state_d = W_COMMIT;
        else if (aw_hs)    state_d = W_ADDR;
        else if (w_hs)     state_d = W_DATA;
      end
      W_ADDR: if (w_hs) state_d = W_COMMIT;
      W_DATA: if (aw_hs) state_d = W_COMMIT;
      W_COMMIT: begin
        state_d  = W_RESP;
        bvalid_d = 1'b1;
        bresp_d  = wr_err ? SLVERR : OKAY;
        // Strobe-masked merge into the addressed word only.
        for (int i = 0; i < 3; i++) begin
          if (!wr_err && awaddr_q[3:2] == 2'(i)) begin
            pulse_d[i] = 1'b1;
            for (int k = 0; k < 4; k++)
              if (wstrb_q[k]) ctrl_d[i][8*k +: 8] = wdata_q[8*k +: 8];
          end
        end
      end
      W_RESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = OKAY;
      // ctrl_q is the pre-commit value when a write lands on the same edge.
      unique case (s_araddr[3:2])
        2'd0: rdata_d = ctrl_q[0];
        2'd1: rdata_d = ctrl_q[1];
        2'd2: rdata_d = ctrl_q[2];
        2'd3: rdata_d = status_in;
        default: rdata_d = '0;
      endcase
      if (s_araddr[1:0] != 2'b00) begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      pulse_q   <= '0;
      ctrl_q[0] <= RST_VAL0;
      ctrl_q[1] <= RST_VAL1;
      ctrl_q[2] <= RST_VAL2;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      pulse_q  <= pulse_d;
      ctrl_q   <= ctrl_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign ctrl0    = ctrl_q[0];
  assign ctrl1    = ctrl_q[1];
  assign ctrl2    = ctrl_q[2];
  assign wr_pulse = pulse_q;

endmodule
